// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the scope acquisition sequencer.
package adc_capture_pkg;

    typedef logic [11:0] sample_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ARMED,
        ST_POST,
        ST_DONE
    } state_t;

    // ADC clock divider setting per timebase index; index 0 is fastest.
    localparam logic [7:0][11:0] TB_TABLE = {
        12'd500, 12'd200, 12'd100, 12'd50, 12'd20, 12'd10, 12'd4, 12'd1
    };

endpackage

// File: rtl/adc_trig_detect.sv
// Level-crossing trigger compare between the previous and current ADC sample.
module adc_trig_detect
    import adc_capture_pkg::*;
(
    input  sample_t prev_sample,
    input  sample_t adc_data,
    input  sample_t trig_level,
    input  logic    trig_falling,
    output logic    hit
);

    always_comb begin
        if (trig_falling)
            hit = (prev_sample > trig_level) && (adc_data <= trig_level);
        else
            hit = (prev_sample < trig_level) && (adc_data >= trig_level);
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Acquisition sequencer: timebase control plus pre/post-trigger capture into a circular RAM.
// Optional auto-trigger timeout is built when ADC_CAPTURE_AUTO_TRIG_EN is defined.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int DEPTH         = 1024,
    parameter int PRE_SAMPLES   = 256,
    parameter int SETTLE_CYCLES = 64,
    parameter int TB_DEFAULT    = 3,
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
    parameter int AUTO_TIMEOUT  = 4096,
`endif
    parameter int ADDR_W        = $clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              tb_up,
    input  logic              tb_down,
    input  logic              arm,
    input  logic              abort,
    input  logic              done_ack,
    input  logic [11:0]       trig_level,
    input  logic              trig_falling,
    input  logic              adc_valid,
    input  logic [11:0]       adc_data,
    output logic [11:0]       counter_max,
    output logic [2:0]        tb_idx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              busy,
    output logic              capture_done,
    output logic              ready
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
    ,
    output logic              auto_trig
`endif
);

    localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_SAMPLES - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(DEPTH - PRE_SAMPLES - 1);
    localparam logic [2:0]       TB_INIT   = 3'(TB_DEFAULT);

    state_t            state;
    logic [SET_W-1:0]  settle_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [CNT_W-1:0]  smp_cnt;     // PRE write count, then POST count incl. trigger sample
    sample_t           prev_sample;
    logic              hit, trig, auto_hit;
    logic              tb_open, step_up, step_dn, tb_chg, arm_go;
    logic [2:0]        tb_next;

    adc_trig_detect u_trig (
        .prev_sample (prev_sample),
        .adc_data    (adc_data),
        .trig_level  (trig_level),
        .trig_falling(trig_falling),
        .hit         (hit)
    );

    assign tb_open = (state == ST_IDLE) || (state == ST_DONE);
    assign step_up = tb_open && tb_up && !tb_down && (tb_idx != 3'd7);
    assign step_dn = tb_open && tb_down && !tb_up && (tb_idx != 3'd0);
    assign tb_chg  = step_up || step_dn;
    assign tb_next = step_up ? tb_idx + 3'd1 : tb_idx - 3'd1;

    assign busy   = (state == ST_PRE) || (state == ST_ARMED) || (state == ST_POST);
    assign ready  = (state == ST_IDLE) && (settle_cnt == '0);
    // A timebase change in the same cycle takes priority over arm.
    assign arm_go = (state == ST_IDLE) && arm && ready && !tb_chg;
    assign trig   = hit || auto_hit;

`ifdef ADC_CAPTURE_AUTO_TRIG_EN
    localparam int AUTO_W = $clog2(AUTO_TIMEOUT + 1);
    logic [AUTO_W-1:0] auto_cnt;

    assign auto_hit = (auto_cnt == AUTO_W'(AUTO_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            auto_cnt  <= '0;
            auto_trig <= 1'b0;
        end else if (arm_go) begin
            auto_cnt  <= '0;
            auto_trig <= 1'b0;
        end else if (state == ST_ARMED && adc_valid && !abort) begin
            auto_cnt <= auto_cnt + AUTO_W'(1);
            if (!hit && auto_hit)
                auto_trig <= 1'b1;
        end
    end
`else
    assign auto_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            tb_idx       <= TB_INIT;
            counter_max  <= TB_TABLE[TB_INIT];
            settle_cnt   <= SET_W'(SETTLE_CYCLES);
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            trig_addr    <= '0;
            capture_done <= 1'b0;
            prev_sample  <= '0;
            wr_ptr       <= '0;
            smp_cnt      <= '0;
        end else begin
            wr_en        <= 1'b0;
            capture_done <= 1'b0;

            if (tb_chg) begin
                tb_idx      <= tb_next;
                counter_max <= TB_TABLE[tb_next];
                settle_cnt  <= SET_W'(SETTLE_CYCLES);
            end else if (settle_cnt != '0) begin
                settle_cnt <= settle_cnt - SET_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (arm_go) begin
                        state   <= ST_PRE;
                        wr_ptr  <= '0;
                        smp_cnt <= '0;
                    end
                end
                ST_PRE, ST_ARMED, ST_POST: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (adc_valid) begin
                        wr_en       <= 1'b1;
                        wr_addr     <= wr_ptr;
                        wr_data     <= adc_data;
                        wr_ptr      <= wr_ptr + ADDR_W'(1);
                        prev_sample <= adc_data;
                        if (state == ST_PRE) begin
                            smp_cnt <= smp_cnt + CNT_W'(1);
                            if (smp_cnt == PRE_LAST)
                                state <= ST_ARMED;
                        end else if (state == ST_ARMED) begin
                            if (trig) begin
                                trig_addr <= wr_ptr;
                                smp_cnt   <= CNT_W'(1);
                                if (POST_LAST == '0) begin
                                    state        <= ST_DONE;
                                    capture_done <= 1'b1;
                                end else begin
                                    state <= ST_POST;
                                end
                            end
                        end else begin
                            smp_cnt <= smp_cnt + CNT_W'(1);
                            if (smp_cnt == POST_LAST) begin
                                state        <= ST_DONE;
                                capture_done <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (done_ack || abort)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomized bench for adc_capture_ctrl against a capture-level reference model.
module tb_adc_capture_ctrl;
    import adc_capture_pkg::*;

    localparam int DEPTH  = 16;
    localparam int PRE    = 4;
    localparam int SETTLE = 64;
    localparam int TBD    = 3;
    localparam int AW     = 4;
    localparam int POST_N = DEPTH - PRE;
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
    localparam int AUTO_TO = 20;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tb_up, tb_down, arm, abort, done_ack, trig_falling, adc_valid;
    logic [11:0]   trig_level, adc_data, counter_max, wr_data;
    logic [2:0]    tb_idx;
    logic          wr_en, busy, capture_done, ready;
    logic [AW-1:0] wr_addr, trig_addr;
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
    logic          auto_trig;
`endif

    int n_chk = 0;
    int n_err = 0;
    int tbl [8] = '{1, 4, 10, 20, 50, 100, 200, 500};

    adc_capture_ctrl #(
        .DEPTH        (DEPTH),
        .PRE_SAMPLES  (PRE),
        .SETTLE_CYCLES(SETTLE),
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
        .AUTO_TIMEOUT (AUTO_TO),
`endif
        .TB_DEFAULT   (TBD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tb_up       (tb_up),
        .tb_down     (tb_down),
        .arm         (arm),
        .abort       (abort),
        .done_ack    (done_ack),
        .trig_level  (trig_level),
        .trig_falling(trig_falling),
        .adc_valid   (adc_valid),
        .adc_data    (adc_data),
        .counter_max (counter_max),
        .tb_idx      (tb_idx),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .trig_addr   (trig_addr),
        .busy        (busy),
        .capture_done(capture_done),
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
        .auto_trig   (auto_trig),
`endif
        .ready       (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!ready && cyc < 500) begin
            tick();
            cyc++;
        end
        if (!ready) check("ready_timeout", 0, 1);
    endtask

    // Index of the sample that becomes the trigger, or -1 if none in the sequence.
    function automatic int find_trig(input sample_t s[$], input sample_t lvl, input logic fall,
                                     output bit is_auto);
        bit h;
        is_auto = 1'b0;
        for (int k = PRE; k < s.size(); k++) begin
            h = fall ? (s[k-1] > lvl && s[k] <= lvl) : (s[k-1] < lvl && s[k] >= lvl);
            if (h) return k;
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
            if (k - PRE + 1 == AUTO_TO) begin
                is_auto = 1'b1;
                return k;
            end
`endif
        end
        return -1;
    endfunction

    task automatic run_capture(input sample_t s[$], input sample_t lvl, input logic fall,
                               input int abort_at, input bit rel_abort);
        bit is_auto;
        int k, last, c, oldest;
        k = find_trig(s, lvl, fall, is_auto);
        if (k < 0) begin
            check("model_no_trigger", 0, 1);
            return;
        end
        last = k + POST_N - 1;
        trig_level   = lvl;
        trig_falling = fall;
        wait_ready(c);
        arm = 1'b1; tick(); arm = 1'b0;
        check("arm_busy", busy, 1);
        for (int i = 0; i <= last; i++) begin
            if (abort_at >= 0 && i == k + abort_at) begin
                abort = 1'b1; tick(); abort = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_ready", ready, 1);
                check("abort_no_done", capture_done, 0);
                for (int j = 0; j < 2; j++) begin
                    adc_valid = 1'b1; adc_data = s[i+j]; tick(); adc_valid = 1'b0;
                    check("abort_no_write", wr_en, 0);
                end
                check("abort_trig_addr_held", trig_addr, k % DEPTH);
                return;
            end
            adc_valid = 1'b1; adc_data = s[i]; tick(); adc_valid = 1'b0;
            check("wr_en", wr_en, 1);
            check("wr_addr", wr_addr, i % DEPTH);
            check("wr_data", wr_data, s[i]);
            check("capture_done", capture_done, i == last);
            check("busy", busy, i != last);
            if (i != last) begin
                repeat ($urandom_range(0, 2)) begin
                    tick();
                    check("gap_wr_en", wr_en, 0);
                end
            end
        end
        check("trig_addr", trig_addr, k % DEPTH);
        oldest = (int'(trig_addr) - PRE + DEPTH) % DEPTH;
        check("oldest_addr", oldest, (k - PRE) % DEPTH);
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
        check("auto_trig", auto_trig, is_auto);
`endif
        tick();
        check("done_pulse_once", capture_done, 0);
        check("done_ready", ready, 0);
        adc_valid = 1'b1; tick(); adc_valid = 1'b0;
        check("done_no_write", wr_en, 0);
        if (rel_abort) abort = 1'b1; else done_ack = 1'b1;
        tick();
        abort = 1'b0; done_ack = 1'b0;
        check("release_ready", ready, 1);
    endtask

    initial begin
        int c, n;
        int exp_idx;
        sample_t s[$];
        sample_t lvl;
        logic fall;
        {tb_up, tb_down, arm, abort, done_ack, adc_valid, trig_falling} = '0;
        adc_data = '0;
        trig_level = 12'h800;

        repeat (3) tick();
        check("rst_tb_idx", tb_idx, TBD);
        check("rst_counter_max", counter_max, tbl[TBD]);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_trig_addr", trig_addr, 0);
        check("rst_capture_done", capture_done, 0);
        rst = 1'b0;

        // arm during settle is dropped
        repeat (10) tick();
        c = 10;
        arm = 1'b1; tick(); arm = 1'b0; c++;
        check("arm_in_settle", busy, 0);
        while (!ready && c < 500) begin tick(); c++; end
        check("settle_after_reset", c, SETTLE);
        arm = 1'b1; tick(); arm = 1'b0;
        check("arm_after_settle", busy, 1);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_pre", busy, 0);

        for (int i = 0; i < 5; i++) begin
            exp_idx = (i < 4) ? 4 + i : 7;
            tb_up = 1'b1; tick(); tb_up = 1'b0;
            check("tb_up_idx", tb_idx, exp_idx);
            check("tb_up_counter_max", counter_max, tbl[exp_idx]);
            check("tb_up_settle_reload", ready, (i < 4) ? 0 : 1);
            wait_ready(c);
            if (i < 4) check("tb_up_settle_len", c, SETTLE);
        end

        tb_up = 1'b1; tb_down = 1'b1; tick(); tb_up = 1'b0; tb_down = 1'b0;
        check("tb_both_idx", tb_idx, 7);
        check("tb_both_ready", ready, 1);

        for (int i = 0; i < 3; i++) begin
            tb_down = 1'b1; tick(); tb_down = 1'b0;
            check("tb_down_idx", tb_idx, 6 - i);
            check("tb_down_counter_max", counter_max, tbl[6-i]);
            wait_ready(c);
        end

        arm = 1'b1; tb_down = 1'b1; tick(); arm = 1'b0; tb_down = 1'b0;
        check("arm_vs_tb_idx", tb_idx, 3);
        check("arm_vs_tb_busy", busy, 0);
        wait_ready(c);

        arm = 1'b1; tick(); arm = 1'b0;
        tb_up = 1'b1; tick(); tb_up = 1'b0;
        check("tb_in_busy_ignored", tb_idx, 3);
        abort = 1'b1; tick(); abort = 1'b0;

        // rising ramp: trigger on 0x800 at address 8
        s = {};
        for (int i = 0; i < 24; i++) s.push_back(sample_t'(i * 256));
        run_capture(s, 12'h800, 1'b0, -1, 1'b0);

        // wrap: trigger lands at address 14
        s = {};
        for (int i = 0; i < 14; i++) s.push_back(12'h000);
        s.push_back(12'hFFF);
        for (int i = 0; i < 16; i++) s.push_back(sample_t'($urandom_range(0, 4095)));
        run_capture(s, 12'h800, 1'b0, -1, 1'b0);

        // falling 0x900 -> 0x700, released by abort in DONE
        s = {};
        for (int i = 0; i < 10; i++) s.push_back(12'h900);
        s.push_back(12'h700);
        for (int i = 0; i < 14; i++) s.push_back(sample_t'($urandom_range(0, 4095)));
        run_capture(s, 12'h800, 1'b1, -1, 1'b1);

        for (int r = 0; r < 6; r++) begin
            fall = 1'($urandom_range(0, 1));
            lvl  = sample_t'($urandom_range(1, 12'hFFE));
            n    = $urandom_range(PRE, 30);
            s = {};
            for (int i = 0; i < n; i++) s.push_back(sample_t'($urandom_range(0, 4095)));
            s.push_back(fall ? 12'hFFF : 12'h000);
            s.push_back(fall ? 12'h000 : 12'hFFF);
            for (int i = 0; i < POST_N; i++) s.push_back(sample_t'($urandom_range(0, 4095)));
            run_capture(s, lvl, fall, (r == 5) ? 3 : -1, 1'b0);
        end

`ifdef ADC_CAPTURE_AUTO_TRIG_EN
        s = {};
        for (int i = 0; i < PRE + AUTO_TO + POST_N; i++) s.push_back(12'h100);
        run_capture(s, 12'h800, 1'b0, -1, 1'b0);
        arm = 1'b1; tick(); arm = 1'b0;
        check("auto_trig_cleared", auto_trig, 0);
        abort = 1'b1; tick(); abort = 1'b0;
`endif

        // reset in the middle of a capture
        tb_up = 1'b1; tick(); tb_up = 1'b0;
        wait_ready(c);
        arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 0; i < 2; i++) begin
            adc_valid = 1'b1; adc_data = 12'h123; tick();
        end
        rst = 1'b1; tick(); rst = 1'b0; adc_valid = 1'b0;
        check("midrst_wr_en", wr_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_tb_idx", tb_idx, TBD);
        check("midrst_counter_max", counter_max, tbl[TBD]);
        check("midrst_trig_addr", trig_addr, 0);
        check("midrst_ready", ready, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
